// File: rtl/regfile_2r1w.sv
// regfile_2r1w: integer register file, two combinational read ports and one
// write-back port. After reset a clearing sequence zeroes x1..x(NREGS-1)
// while init_busy holds the pipeline off.
// Build option: define REGFILE_WRITE_THROUGH_EN to forward the write-back
// data onto a read port that addresses the register being written.
//
// state | meaning
// ------+------------------------------------------------------------------
// CLEAR | zeroing one register per cycle, writes dropped, reads return 0
// READY | normal operation, writes committed and counted
module regfile_2r1w #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NREGS  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re1,
    input  logic [ADDR_W-1:0] raddr1,
    output logic [DATA_W-1:0] rdata1,
    input  logic              re2,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] rdata2,
    output logic              init_busy,
    output logic [15:0]       wr_count
);

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NREGS - 1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] clr_idx_q, clr_idx_d;
    logic [DATA_W-1:0] regs [NREGS];
    logic              wr_commit;

    // x0 is never a real write target, so it neither stores nor counts
    assign wr_commit = (state_q == READY) && we && (waddr != '0);
    assign init_busy = (state_q == CLEAR);

    // State register and clear pointer; reset restarts clearing at x1
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= CLEAR;
            clr_idx_q <= ADDR_W'(1);
        end else begin
            state_q   <= state_d;
            clr_idx_q <= clr_idx_d;
        end
    end

    // Next-state: walk the clear pointer up to the last register, then go READY
    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        case (state_q)
            CLEAR: begin
                clr_idx_d = clr_idx_q + ADDR_W'(1);
                if (clr_idx_q == LAST_IDX) begin
                    state_d = READY;
                end
            end
            READY: begin
                state_d = READY;
            end
            default: begin
                state_d = CLEAR;
            end
        endcase
    end

    // Storage: clearing owns the array in CLEAR, write-back owns it in READY
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state_q == CLEAR) begin
                regs[clr_idx_q] <= '0;
            end else if (wr_commit) begin
                regs[waddr] <= wdata;
            end
        end
    end

    // Committed-write counter, sticks at all-ones rather than wrapping
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_count <= '0;
        end else if (wr_commit && (wr_count != 16'hFFFF)) begin
            wr_count <= wr_count + 16'd1;
        end
    end

    // Read port 1: forced zero during reset/clear, disabled or x0 reads
    always_comb begin
        rdata1 = '0;
        if (rst || (state_q == CLEAR)) begin
            rdata1 = '0;
        end else if (!re1) begin
            rdata1 = '0;
        end else if (raddr1 == '0) begin
            rdata1 = '0;
`ifdef REGFILE_WRITE_THROUGH_EN
        end else if (we && (waddr == raddr1)) begin
            rdata1 = wdata;
`endif
        end else begin
            rdata1 = regs[raddr1];
        end
    end

    // Read port 2: same priority as port 1, fully independent
    always_comb begin
        rdata2 = '0;
        if (rst || (state_q == CLEAR)) begin
            rdata2 = '0;
        end else if (!re2) begin
            rdata2 = '0;
        end else if (raddr2 == '0) begin
            rdata2 = '0;
`ifdef REGFILE_WRITE_THROUGH_EN
        end else if (we && (waddr == raddr2)) begin
            rdata2 = wdata;
`endif
        end else begin
            rdata2 = regs[raddr2];
        end
    end

endmodule

// File: tb/tb_regfile_2r1w.sv
// Directed bench for regfile_2r1w with hand-computed expected values.
// Honours REGFILE_WRITE_THROUGH_EN to pick the same-cycle read expectation.
module tb_regfile_2r1w;

    logic        clk;
    logic        rst;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        re1;
    logic [4:0]  raddr1;
    logic [31:0] rdata1;
    logic        re2;
    logic [4:0]  raddr2;
    logic [31:0] rdata2;
    logic        init_busy;
    logic [15:0] wr_count;

    int n_tests;
    int n_fail;
    int busy_cycles;

    regfile_2r1w #(
        .DATA_W(32),
        .ADDR_W(5),
        .NREGS (32)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .we       (we),
        .waddr    (waddr),
        .wdata    (wdata),
        .re1      (re1),
        .raddr1   (raddr1),
        .rdata1   (rdata1),
        .re2      (re2),
        .raddr2   (raddr2),
        .rdata2   (rdata2),
        .init_busy(init_busy),
        .wr_count (wr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // advance one edge; inputs are changed and outputs sampled 1ns after it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // count cycles until init_busy drops, bounded
    task automatic wait_clear(output int cycles);
        cycles = 0;
        while (init_busy && cycles < 100) begin
            tick();
            cycles++;
        end
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        we = 1'b1; waddr = a; wdata = d;
        tick();
        we = 1'b0;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst = 1'b1; we = 1'b0; waddr = '0; wdata = '0;
        re1 = 1'b1; raddr1 = 5'd1; re2 = 1'b1; raddr2 = 5'd2;
        tick();
        tick();
        #1;
        chk("rst_busy", 32'(init_busy), 32'd1);
        chk("rst_count", 32'(wr_count), 32'd0);
        chk("rst_rd1", rdata1, 32'd0);

        // clearing sequence
        rst = 1'b0;
        wait_clear(busy_cycles);
        chk("clear_len", 32'(busy_cycles), 32'd31);
        chk("ready_busy", 32'(init_busy), 32'd0);
        for (int i = 1; i < 32; i++) begin
            raddr1 = 5'(i);
            raddr2 = 5'(32 - i);
            #1;
            chk("clear_rd1", rdata1, 32'd0);
            chk("clear_rd2", rdata2, 32'd0);
        end
        chk("clear_count", 32'(wr_count), 32'd0);

        // write then read
        re1 = 1'b0; re2 = 1'b0;
        wr(5'd5, 32'hDEADBEEF);
        re1 = 1'b1; raddr1 = 5'd5;
        #1;
        chk("wr_rd_x5", rdata1, 32'hDEADBEEF);
        chk("wr_count1", 32'(wr_count), 32'd1);

        // x0 write dropped and disabled port returns zero
        re1 = 1'b0;
        wr(5'd0, 32'h12345678);
        re1 = 1'b1; raddr1 = 5'd0; re2 = 1'b0; raddr2 = 5'd5;
        #1;
        chk("x0_rd1", rdata1, 32'd0);
        chk("dis_rd2", rdata2, 32'd0);
        chk("x0_count", 32'(wr_count), 32'd1);
        re2 = 1'b1;
        #1;
        chk("en_rd2_x5", rdata2, 32'hDEADBEEF);

        // a few more distinct patterns on both ports
        wr(5'd31, 32'hFFFF_FFFF);
        wr(5'd1, 32'h0000_0001);
        raddr1 = 5'd31; raddr2 = 5'd1;
        #1;
        chk("rd1_x31", rdata1, 32'hFFFF_FFFF);
        chk("rd2_x1", rdata2, 32'h0000_0001);
        raddr1 = 5'd5; raddr2 = 5'd5;
        #1;
        chk("same_rd1", rdata1, 32'hDEADBEEF);
        chk("same_rd2", rdata2, 32'hDEADBEEF);
        chk("wr_count3", 32'(wr_count), 32'd3);

        // same-cycle write and read of x7
        wr(5'd7, 32'h0000_0001);
        we = 1'b1; waddr = 5'd7; wdata = 32'hA5A5A5A5;
        raddr1 = 5'd7; raddr2 = 5'd7;
        #1;
`ifdef REGFILE_WRITE_THROUGH_EN
        chk("wt_rd1", rdata1, 32'hA5A5A5A5);
        chk("wt_rd2", rdata2, 32'hA5A5A5A5);
`else
        chk("wt_rd1", rdata1, 32'h0000_0001);
        chk("wt_rd2", rdata2, 32'h0000_0001);
`endif
        tick();
        we = 1'b0;
        #1;
        chk("wt_next_rd1", rdata1, 32'hA5A5A5A5);
        chk("wt_next_rd2", rdata2, 32'hA5A5A5A5);
        chk("wr_count5", 32'(wr_count), 32'd5);

        // reset mid-operation, then again 10 cycles into the new CLEAR
        wr(5'd3, 32'h55);
        raddr1 = 5'd3;
        #1;
        chk("x3_pre", rdata1, 32'h55);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 9; i++) tick();
        chk("mid_busy", 32'(init_busy), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        we = 1'b1; waddr = 5'd3; wdata = 32'h99;
        #1;
        chk("clr_rd_forced", rdata1, 32'd0);
        wait_clear(busy_cycles);
        we = 1'b0;
        chk("reclear_len", 32'(busy_cycles), 32'd31);
        #1;
        chk("x3_cleared", rdata1, 32'd0);
        raddr2 = 5'd5;
        #1;
        chk("x5_cleared", rdata2, 32'd0);
        chk("clr_wr_dropped", 32'(wr_count), 32'd0);

        // counter saturation
        we = 1'b1; waddr = 5'd1;
        for (int i = 0; i < 65534; i++) begin
            wdata = 32'(i);
            tick();
        end
        chk("count_fffe", 32'(wr_count), 32'h0000_FFFE);
        for (int i = 65534; i < 65540; i++) begin
            wdata = 32'(i);
            tick();
        end
        we = 1'b0;
        #1;
        chk("count_sat", 32'(wr_count), 32'h0000_FFFF);
        raddr1 = 5'd1;
        #1;
        chk("x1_last", rdata1, 32'd65539);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_2r1w.md
Name: regfile_2r1w

Overview:
- Integer register file for the 5-stage RISC-V pipeline. It is the responder side of the decode stage's register-read interface: it answers the re1/reg_addr1 and re2/reg_addr2 requests with reg_data1/reg_data2 in the same cycle.
- It accepts the single write-back port from the WB stage.
- After reset it runs a clearing sequence and holds the pipeline off via a stall request until every register is zero.

Parameters:
- DATA_W, 32, register width in bits
- ADDR_W, 5, register address width
- NREGS, 32, number of architectural registers (2**ADDR_W); x0 is hardwired to zero

Ports:
- clk  in  1  pipeline clock
- rst  in  1  synchronous, active-high reset
- we  in  1  write enable from WB stage
- waddr  in  ADDR_W  write register index
- wdata  in  DATA_W  write data
- re1  in  1  read enable, port 1
- raddr1  in  ADDR_W  read index, port 1
- rdata1  out  DATA_W  read data, port 1 (combinational)
- re2  in  1  read enable, port 2
- raddr2  in  ADDR_W  read index, port 2
- rdata2  out  DATA_W  read data, port 2 (combinational)
- init_busy  out  1  clearing sequence active; ORed into pipeline stall
- wr_count  out  16  count of committed architectural writes (saturating)

Behaviour:
- Reset, interface and storage:
  - Reset is synchronous, active-high, single clock domain clk.
  - Storage is NREGS x DATA_W flops. Entry 0 is never written; any read of index 0 returns 0.
- State machine: states CLEAR and READY.
  - rst high at a clk edge: state<=CLEAR, clr_idx<=1, wr_count<=0, init_busy=1.
  - rst has priority over everything.
  - CLEAR: each cycle regs[clr_idx]<=0 and clr_idx<=clr_idx+1. When clr_idx==NREGS-1 (that entry is cleared on the same edge), state<=READY.
  - CLEAR lasts NREGS-1 = 31 cycles after rst falls. init_busy is 1 throughout CLEAR and 0 in READY.
  - CLEAR: we is ignored, no write and no count. rdata1/rdata2 are forced to 0.
  - rst reasserted mid-CLEAR or in READY restarts the sequence from clr_idx=1.
- Write (READY only):
  - If we=1 and waddr!=0: regs[waddr]<=wdata at the clk edge, and wr_count increments, saturating at 16'hFFFF.
  - If we=1 and waddr==0: no storage change and no count.
- Read, per port n, combinational and evaluated in priority order:
  - rst=1 or state==CLEAR -> 0
  - ren=0 -> 0
  - raddrn==0 -> 0
  - write-through hit (see Optional Feature) -> wdata
  - otherwise -> regs[raddrn]
- Both ports are independent. Same address on both ports returns identical data.
- Latency:
  - Read is 0 cycles (combinational).
  - Write is visible at the array output on the cycle after the edge.

Optional Feature:
- Macro: REGFILE_WRITE_THROUGH_EN.
- Defined:
  - In READY, if ren=1, we=1, waddr==raddrn and waddr!=0, then rdata=wdata in the same cycle.
  - This resolves the WB-to-ID hazard that EX/MEM forwarding in decode does not cover.
- Undefined:
  - The read returns the old array value until the next cycle.
  - The pipeline must insert a bubble for a WB/ID same-register overlap.
- Storage and write timing are identical in both builds.

Test Plan:
- Clearing sequence:
  - Stimulus: rst=1 for 2 cycles, then rst=0.
  - Response: init_busy stays 1 for exactly 31 cycles, then 0.
  - Response: afterwards, reads of x1..x31 return 0 and wr_count==0.
- Write then read:
  - Stimulus: in READY, we=1 waddr=5 wdata=32'hDEADBEEF for 1 cycle; next cycle re1=1 raddr1=5.
  - Response: rdata1=32'hDEADBEEF and wr_count==1.
- x0 write and disabled read:
  - Stimulus: we=1 waddr=0 wdata=32'h12345678; then re1=1 raddr1=0; re2=0 raddr2=5.
  - Response: rdata1=0, rdata2=0, wr_count unchanged.
- Write-through, same cycle:
  - Stimulus: we=1 waddr=7 wdata=32'hA5A5A5A5, re1=1 raddr1=7, re2=1 raddr2=7, x7 previously 32'h1.
  - With REGFILE_WRITE_THROUGH_EN: rdata1=rdata2=32'hA5A5A5A5.
  - Without it: rdata1=rdata2=32'h1; next cycle both read 32'hA5A5A5A5.
- Reset mid-operation:
  - Stimulus: write x3=32'h55; assert rst at cycle 10 of a new CLEAR; deassert.
  - Response: init_busy is 1 for a further 31 cycles from deassertion.
  - Response: a write attempt during CLEAR is dropped; x3 reads 0 after CLEAR.
- Counter saturation:
  - Stimulus: preload wr_count near max via 65 540 writes to x1.
  - Response: wr_count holds 16'hFFFF.
